// File: rtl/arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arb_pkg : shared state encoding and default sizing for the VC arbiter     |
// | rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
package arb_pkg;

  localparam int NUM_SRC_DEF   = 4;
  localparam int DATA_SIZE_DEF = 8;
  localparam int BURST_LEN_DEF = 4;
  localparam int SEL_W_DEF     = $clog2(NUM_SRC_DEF);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // A single source still needs a 1-bit index.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_pick : combinational rotating-priority picker, scans from last+1       |
// | rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int SEL_W   = sel_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest offset down so the nearest requester after 'last' wins.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      cand = SEL_W'((int'(last) + i) % NUM_SRC);
      if (req[cand]) begin
        gnt_idx   = cand;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vc_fifo_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vc_fifo_rr_arbiter : round-robin burst drain of NUM_SRC VC FIFOs into one |
// | downstream FIFO. Option ARB_STRICT_VC0_EN gives source 0 strict priority. |
// | rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
module vc_fifo_rr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_SRC   = NUM_SRC_DEF,
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int SEL_W     = sel_width(NUM_SRC)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_SRC-1:0]             src_empty,
  input  logic [NUM_SRC*DATA_SIZE-1:0]   src_data,
  input  logic                           dst_pause,
  input  logic                           dst_full,
  output logic [NUM_SRC-1:0]             src_pop,
  output logic                           dst_push,
  output logic [DATA_SIZE-1:0]           dst_data,
  output logic [SEL_W-1:0]               grant_idx,
  output logic                           busy
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  arb_state_e         state;
  logic [CNT_W-1:0]   burst_cnt;
  logic [SEL_W-1:0]   rr_last;
  logic               pipe_valid;
  logic [SEL_W-1:0]   pipe_idx;

  logic [DATA_SIZE-1:0] words [NUM_SRC];
  logic                 can_pop;
  logic [SEL_W-1:0]     pick_idx;
  logic                 pick_valid;
  logic [SEL_W-1:0]     sel_idx;
  logic                 pop_any;
  logic [SEL_W-1:0]     pop_idx;
  logic                 burst_done;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign words[i] = src_data[i*DATA_SIZE +: DATA_SIZE];
  end

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_pick (
    .req       (~src_empty),
    .last      (rr_last),
    .gnt_idx   (pick_idx),
    .gnt_valid (pick_valid)
  );

  assign can_pop    = enable & ~dst_pause & ~dst_full;
  assign burst_done = (burst_cnt == CNT_W'(BURST_LEN)) | src_empty[grant_idx] | ~enable;

  always_comb begin
`ifdef ARB_STRICT_VC0_EN
    sel_idx = src_empty[0] ? pick_idx : '0;
`else
    sel_idx = pick_idx;
`endif
    pop_any = 1'b0;
    pop_idx = grant_idx;
    case (state)
      ST_IDLE: begin
        pop_any = can_pop & pick_valid;
        pop_idx = sel_idx;
      end
      ST_BURST: begin
        pop_any = can_pop & ~src_empty[grant_idx] & (burst_cnt < CNT_W'(BURST_LEN));
      end
      default: pop_any = 1'b0;
    endcase
  end

  // Strobe is masked during reset so no word is removed from a source while it is held.
  assign src_pop = (reset && pop_any) ? (NUM_SRC'(1) << pop_idx) : '0;
  assign busy    = (state == ST_BURST) | pipe_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      burst_cnt  <= '0;
      rr_last    <= SEL_W'(NUM_SRC - 1);
      grant_idx  <= '0;
      pipe_valid <= 1'b0;
      pipe_idx   <= '0;
      dst_push   <= 1'b0;
      dst_data   <= '0;
    end else begin
      // Stage 1 remembers who was popped; stage 2 captures the word the source now presents.
      pipe_valid <= pop_any;
      pipe_idx   <= pop_idx;
      dst_push   <= pipe_valid;
      if (pipe_valid) begin
        dst_data <= words[pipe_idx];
      end

      case (state)
        ST_IDLE: begin
          if (pop_any) begin
            state     <= ST_BURST;
            grant_idx <= pop_idx;
            burst_cnt <= CNT_W'(1);
          end
        end
        ST_BURST: begin
          if (burst_done) begin
            state     <= ST_IDLE;
            rr_last   <= grant_idx;
            burst_cnt <= '0;
          end else if (pop_any) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vc_fifo_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vc_fifo_rr_arbiter : directed bench with behavioural source FIFOs      |
// | rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
module tb_vc_fifo_rr_arbiter;

  localparam int NS = 4;
  localparam int DW = 8;
  localparam int NONE = 15;

  logic            clk;
  logic            reset;
  logic            enable;
  logic [NS-1:0]   src_empty;
  logic [NS*DW-1:0] src_data;
  logic            dst_pause;
  logic            dst_full;
  logic [NS-1:0]   src_pop;
  logic            dst_push;
  logic [DW-1:0]   dst_data;
  logic [1:0]      grant_idx;
  logic            busy;

  logic [DW-1:0]   wd [NS];
  byte unsigned    q  [NS][$];

  int pop_log [64];
  int push_v  [64];
  int push_d  [64];
  int busy_log[64];
  int grant_log[64];
  int cyc;
  int n_checks;
  int n_errors;

  assign src_data = {wd[3], wd[2], wd[1], wd[0]};

  vc_fifo_rr_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .src_empty (src_empty),
    .src_data  (src_data),
    .dst_pause (dst_pause),
    .dst_full  (dst_full),
    .src_pop   (src_pop),
    .dst_push  (dst_push),
    .dst_data  (dst_data),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int s, input int b);
    q[s].push_back(8'(b));
    src_empty[s] = 1'b0;
  endtask

  task automatic flush();
    for (int i = 0; i < NS; i++) q[i].delete();
    src_empty = '1;
  endtask

  // One clock: sample mid-cycle, then let the source models react to this cycle's pops.
  task automatic tick();
    logic [NS-1:0] pop;
    logic [NS-1:0] emp;
    int idx;
    #1;
    pop = src_pop;
    idx = NONE;
    for (int i = 0; i < NS; i++) if (pop[i]) idx = i;
    if ($countones(pop) > 1) idx = 14;
    check("pop_onehot", int'($countones(pop) <= 1), 1);
    check("pop_of_empty", int'(pop & src_empty), 0);
    pop_log[cyc]   = idx;
    push_v[cyc]    = int'(dst_push);
    push_d[cyc]    = int'(dst_data);
    busy_log[cyc]  = int'(busy);
    grant_log[cyc] = int'(grant_idx);
    cyc++;
    @(posedge clk);
    for (int i = 0; i < NS; i++) begin
      if (pop[i] && q[i].size() > 0) wd[i] <= q[i].pop_front();
      emp[i] = (q[i].size() == 0);
    end
    src_empty <= emp;
    @(negedge clk);
  endtask

  task automatic verify(input string tag, input int ep[$], input int eq[$]);
    for (int c = 0; c < ep.size(); c++)
      check($sformatf("%s_pop_c%0d", tag, c), pop_log[c], ep[c]);
    for (int c = 0; c < eq.size(); c++) begin
      check($sformatf("%s_push_c%0d", tag, c), push_v[c], int'(eq[c] >= 0));
      if (eq[c] >= 0) check($sformatf("%s_data_c%0d", tag, c), push_d[c], eq[c]);
    end
  endtask

  initial begin
    int ep[$];
    int eq[$];
    int k[NS];
    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    reset     = 1'b0;
    enable    = 1'b0;
    dst_pause = 1'b0;
    dst_full  = 1'b0;
    src_empty = '1;
    for (int i = 0; i < NS; i++) wd[i] = '0;

    repeat (2) @(negedge clk);
    check("rst_pop",   int'(src_pop), 0);
    check("rst_push",  int'(dst_push), 0);
    check("rst_data",  int'(dst_data), 0);
    check("rst_grant", int'(grant_idx), 0);
    check("rst_busy",  int'(busy), 0);
    reset = 1'b1;

    // 1: all four sources hold six words, round-robin bursts of four.
    for (int i = 0; i < NS; i++) for (int w = 0; w < 6; w++) load(i, i*16 + w);
    enable = 1'b1;
    cyc = 0;
    repeat (36) tick();
    ep = '{0,0,0,0,NONE, 1,1,1,1,NONE, 2,2,2,2,NONE, 3,3,3,3,NONE,
           0,0,NONE, 1,1,NONE, 2,2,NONE, 3,3,NONE, NONE};
    eq.delete();
    for (int i = 0; i < NS; i++) k[i] = 0;
    for (int c = 0; c < 36; c++) begin
      if (c >= 2 && c - 2 < ep.size() && ep[c-2] != NONE) begin
        eq.push_back(ep[c-2]*16 + k[ep[c-2]]);
        k[ep[c-2]]++;
      end else begin
        eq.push_back(-1);
      end
    end
    verify("t1", ep, eq);

    // 2: lone source 2 with two words ends its burst on empty.
    load(2, 'hA1);
    load(2, 'hA2);
    cyc = 0;
    repeat (6) tick();
    verify("t2", '{2,2,NONE,NONE,NONE,NONE}, '{-1,-1,'hA1,'hA2,-1,-1});
    check("t2_grant", grant_log[2], 2);
    check("t2_busy0", busy_log[0], 0);
    check("t2_busy1", busy_log[1], 1);
    check("t2_busy2", busy_log[2], 1);
    check("t2_busy3", busy_log[3], 0);
    check("t2_hold",  push_d[5], 'hA2);

    // 3: pause for three cycles after two pops; burst count must be frozen at 2.
    for (int w = 0; w < 6; w++) load(1, 'h50 + w);
    cyc = 0;
    repeat (2) tick();
    dst_pause = 1'b1;
    repeat (3) tick();
    dst_pause = 1'b0;
    repeat (8) tick();
    verify("t3", '{1,1,NONE,NONE,NONE,1,1,NONE,1,1,NONE,NONE,NONE},
                 '{-1,-1,'h50,'h51,-1,-1,-1,'h52,'h53,-1,'h54,'h55,-1});
    check("t3_grant_paused", grant_log[4], 1);

    // 4: one reset cycle mid-burst drops the in-flight word and restarts at source 0.
    for (int w = 0; w < 4; w++) load(3, 'h70 + w);
    cyc = 0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    load(0, 'h80);
    load(0, 'h81);
    repeat (8) tick();
    verify("t4", '{3,3,NONE,0,0,NONE,3,3,NONE,NONE,NONE},
                 '{-1,-1,'h70,-1,-1,'h80,'h81,-1,'h72,'h73,-1});
    check("t4_data_after_rst",  push_d[3], 0);
    check("t4_grant_after_rst", grant_log[3], 0);
    check("t4_busy_after_rst",  busy_log[3], 0);

    // 5: disabled arbiter issues nothing; enabling starts at source 0.
    enable = 1'b0;
    for (int i = 0; i < NS; i++) begin
      load(i, 'hC0 + i*16);
      load(i, 'hC1 + i*16);
    end
    cyc = 0;
    repeat (10) tick();
    enable = 1'b1;
    repeat (4) tick();
    verify("t5", '{NONE,NONE,NONE,NONE,NONE,NONE,NONE,NONE,NONE,NONE,0,0,NONE,1},
                 '{-1,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1,'hC0,'hC1});
    check("t5_busy_disabled", busy_log[9], 0);
    repeat (12) tick();

    // 6: sources 0 and 1 permanently busy.
    for (int w = 0; w < 40; w++) begin
      load(0, w);
      load(1, 'h40 + w);
    end
    cyc = 0;
    repeat (15) tick();
`ifdef ARB_STRICT_VC0_EN
    verify("t6", '{0,0,0,0,NONE,0,0,0,0,NONE,0,0,0,0,NONE}, '{});
`else
    verify("t6", '{0,0,0,0,NONE,1,1,1,1,NONE,0,0,0,0,NONE}, '{});
`endif
    flush();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
